// File: rtl/nbit_serial_add.sv
// ============================================================================
// Module      : nbit_serial_add
// Description : Digit-serial N-bit adder with carry/zero/overflow/negative
//               flags; DIGIT bits summed per clock, one-cycle done pulse.
//               Optional subtract mode enabled by `define SERIAL_ADD_SUB_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nbit_serial_add #(
  parameter int N     = 32,
  parameter int DIGIT = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic         sub,
`endif
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         cry_flag,
  output logic         zr_flag,
  output logic         of_flag,
  output logic         neg_flag
);

  localparam int c_NUM = N / DIGIT;
  localparam int c_CW  = (c_NUM > 1) ? $clog2(c_NUM) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(c_NUM - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            w_accept;
  logic            w_last;
  logic            w_sub;

  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;
  logic [c_CW-1:0] r_cnt;
  logic            r_carry;
  logic            r_done;

  logic [DIGIT-1:0] w_a_dig;
  logic [DIGIT-1:0] w_b_dig;
  logic [DIGIT-1:0] w_sum;
  logic             w_cout;
  logic [N-1:0]     w_a_next;
  logic [N-1:0]     w_b_next;

`ifdef SERIAL_ADD_SUB_EN
  assign w_sub = sub;
`else
  assign w_sub = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (r_cnt == c_LAST) begin
          w_last       = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign busy = (r_state == RUN);
  assign done = r_done;

  assign w_a_dig          = r_a[DIGIT-1:0];
  assign w_b_dig          = r_b[DIGIT-1:0];
  assign {w_cout, w_sum}  = {1'b0, w_a_dig} + {1'b0, w_b_dig} + (DIGIT+1)'(r_carry);

  // r_a doubles as the accumulator: sum digits enter at the top as operand
  // digits leave at the bottom, so after N/DIGIT steps it holds the result.
  generate
    if (c_NUM > 1) begin : g_multi
      assign w_a_next = {w_sum, r_a[N-1:DIGIT]};
      assign w_b_next = {{DIGIT{1'b0}}, r_b[N-1:DIGIT]};
    end else begin : g_single
      assign w_a_next = w_sum;
      assign w_b_next = r_b;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_done   <= 1'b0;
      result   <= '0;
      cry_flag <= 1'b0;
      zr_flag  <= 1'b0;
      of_flag  <= 1'b0;
      neg_flag <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_a     <= a;
        r_b     <= w_sub ? ~b : b;
        r_carry <= w_sub;
        r_cnt   <= '0;
      end else if (busy) begin
        r_a     <= w_a_next;
        r_b     <= w_b_next;
        r_carry <= w_cout;
        r_cnt   <= r_cnt + c_CW'(1);
      end
      // On the last step the digit MSBs are the operand sign bits.
      if (w_last) begin
        result   <= w_a_next;
        cry_flag <= w_cout;
        zr_flag  <= (w_a_next == '0);
        neg_flag <= w_a_next[N-1];
        of_flag  <= (w_a_dig[DIGIT-1] == w_b_dig[DIGIT-1]) &
                    (w_sum[DIGIT-1] != w_a_dig[DIGIT-1]);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_nbit_serial_add.sv
// ============================================================================
// Module      : tb_nbit_serial_add
// Description : Directed self-checking bench for nbit_serial_add (N=32, DIGIT=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nbit_serial_add;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        cry_flag;
  logic        zr_flag;
  logic        of_flag;
  logic        neg_flag;

  int n_checks = 0;
  int n_fail   = 0;

  nbit_serial_add #(.N(32), .DIGIT(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
`ifdef SERIAL_ADD_SUB_EN
    .sub      (sub),
`endif
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cry_flag (cry_flag),
    .zr_flag  (zr_flag),
    .of_flag  (of_flag),
    .neg_flag (neg_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [31:0] er,
                           input logic ec, input logic ez, input logic eo, input logic en);
    check({tag, ".result"}, 64'(result), 64'(er));
    check({tag, ".cry"},    64'(cry_flag), 64'(ec));
    check({tag, ".zr"},     64'(zr_flag),  64'(ez));
    check({tag, ".of"},     64'(of_flag),  64'(eo));
    check({tag, ".neg"},    64'(neg_flag), 64'(en));
  endtask

  // Called just after an edge; returns just after the accepting edge.
  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts);
    a     = ta;
    b     = tb_v;
    sub   = ts;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Returns in the done cycle; lat = edges after acceptance, -1 on timeout.
  task automatic wait_done(output int lat, output int bc);
    lat = -1;
    bc  = busy ? 1 : 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        return;
      end
      if (busy) bc++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic ts, input logic [31:0] er,
                        input logic ec, input logic ez, input logic eo, input logic en);
    int lat, bc;
    start_op(ta, tb_v, ts);
    check({tag, ".busy_start"}, 64'(busy), 64'(1));
    wait_done(lat, bc);
    check({tag, ".latency"}, 64'(lat), 64'(4));
    check({tag, ".busy_cycles"}, 64'(bc), 64'(4));
    check({tag, ".busy_at_done"}, 64'(busy), 64'(0));
    check_out(tag, er, ec, ez, eo, en);
    @(posedge clk); #1;
    check({tag, ".done_drop"}, 64'(done), 64'(0));
  endtask

  initial begin
    int lat, bc;
    logic seen_done;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    sub   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.busy", 64'(busy), 64'(0));
    check("reset.done", 64'(done), 64'(0));
    check_out("reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("add_1_2",     32'h00000001, 32'h00000002, 1'b0, 32'h00000003, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("add_wrap",    32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0);
    run_op("add_ovf",     32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b1);
    run_op("add_negneg",  32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0);
    run_op("add_mixed",   32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0, 1'b0, 1'b0, 1'b1);

`ifdef SERIAL_ADD_SUB_EN
    run_op("sub_5_3",     32'h00000005, 32'h00000003, 1'b1, 32'h00000002, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op("sub_3_5",     32'h00000003, 32'h00000005, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op("sub_ovf",     32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
`endif

    // Start while busy is ignored; operand changes after acceptance too.
    start_op(32'd5, 32'd3, 1'b0);
    @(posedge clk); #1;
    a     = 32'd9;
    b     = 32'd9;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, bc);
    check("ignore.latency", 64'(lat), 64'(2));
    check_out("ignore", 32'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("ignore.no_second_op", 64'(busy), 64'(0));

    // Reset mid-run abandons the operation and clears the outputs.
    start_op(32'd9, 32'd9, 1'b0);
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    check("midrst.busy", 64'(busy), 64'(0));
    check("midrst.done", 64'(done), 64'(0));
    check_out("midrst", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) seen_done = 1'b1;
    end
    check("midrst.no_done", 64'(seen_done), 64'(0));
    check("midrst.idle", 64'(busy), 64'(0));

    // Start held high: each op samples the operands present at its acceptance edge.
    a     = 32'h00000010;
    b     = 32'h00000020;
    sub   = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    a = 32'hFFFF0000;
    b = 32'h00010000;
    wait_done(lat, bc);
    check("hold0.latency", 64'(lat), 64'(4));
    check_out("hold0", 32'h00000030, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("hold1.busy_next", 64'(busy), 64'(1));
    check("hold1.done_once", 64'(done), 64'(0));
    a = 32'h40000000;
    b = 32'h40000000;
    wait_done(lat, bc);
    check("hold1.latency", 64'(lat), 64'(4));
    check_out("hold1", 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("hold2.busy_next", 64'(busy), 64'(1));
    start = 1'b0;
    a = 32'h0;
    b = 32'h0;
    wait_done(lat, bc);
    check("hold2.latency", 64'(lat), 64'(4));
    check_out("hold2", 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    check("hold2.idle", 64'(busy), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
